// File: rtl/tx_uart_if.sv
// Write-side port of the UART transmitter: byte strobe plus FIFO status flags.
interface tx_uart_if;
    logic       data_wr;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (
        output data_wr,
        output din,
        input  full,
        input  empty,
        input  overflow
    );

    modport slave (
        input  data_wr,
        input  din,
        output full,
        output empty,
        output overflow
    );
endinterface

// File: rtl/tx_uart.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits, LSB first
// STOP  | stop bit (1); chains straight into the next start bit if data waits
module tx_uart #(
    parameter int SYSTEM_CLK = 100_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int DEPTH      = 16
) (
    input  logic      clk,
    input  logic      resetn,
    tx_uart_if.slave  bus,
    output logic      tx_out,
    output logic      busy
);
    localparam int CPS = SYSTEM_CLK / BAUDRATE;
    localparam int CW  = $clog2(SYSTEM_CLK);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CPS - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign bus.full  = (count == COUNT_FULL);
    assign bus.empty = (count == '0);
    assign push      = bus.data_wr && !bus.full;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.overflow <= bus.data_wr && bus.full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.din;
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          tx_n;
    logic          sym_end;

    // Symbol timer counts down from CPS-1; the edge at which it reads zero ends the symbol.
    assign sym_end = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx_out  <= tx_n;
            busy    <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = sym_end ? cnt : cnt - 1'b1;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        tx_n      = tx_out;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!bus.empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                    cnt_n   = CNT_RELOAD;
                    state_n = START;
                end
            end
            START: begin
                if (sym_end) begin
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    cnt_n     = CNT_RELOAD;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (sym_end) begin
                    cnt_n = CNT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sym_end) begin
                    if (!bus.empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                        cnt_n   = CNT_RELOAD;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: frame-timing reference model, line decoder and directed scenarios.
module tb_tx_uart;
    localparam int SYSTEM_CLK = 1_000_000;
    localparam int BAUDRATE   = 100_000;
    localparam int DEPTH      = 4;
    localparam int CPS        = SYSTEM_CLK / BAUDRATE;
    localparam int FRAME      = 10 * CPS;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic tx_out;
    logic busy;

    tx_uart_if bus ();

    tx_uart #(.SYSTEM_CLK(SYSTEM_CLK), .BAUDRATE(BAUDRATE), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .tx_out (tx_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the time elapsed in the current frame.
    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    bit         m_active = 1'b0;
    int         m_t = 0;
    bit         m_ovf = 1'b0;

    function automatic logic exp_line(input logic [7:0] b, input int t);
        int k;
        k = t / CPS;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin
        bit full_pre;
        if (!resetn) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            m_ovf    = bus.data_wr && full_pre;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (mq.size() > 0) begin
                        m_byte = mq.pop_front();
                        m_t    = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (bus.data_wr && !full_pre) mq.push_back(bus.din);
        end
    end

    int busy_cycles = 0;
    int ovf_cnt = 0;

    always @(negedge clk) begin
        chk("tx_out",   tx_out,       m_active ? exp_line(m_byte, m_t) : 1'b1);
        chk("busy",     busy,         m_active);
        chk("empty",    bus.empty,    mq.size() == 0);
        chk("full",     bus.full,     mq.size() == DEPTH);
        chk("overflow", bus.overflow, m_ovf);
        if (busy) busy_cycles++;
        if (bus.overflow) ovf_cnt++;
    end

    // Line decoder: samples mid-symbol and collects received bytes.
    logic [7:0] rx_q[$];
    logic [9:0] rx_bits = '0;
    logic [9:0] last_bits = '0;
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    logic       tx_prev = 1'b1;

    always @(negedge clk) begin
        if (!busy) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx_prev == 1'b1 && tx_out == 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_on && (rx_t % CPS) == CPS / 2) begin
            rx_bits[rx_t / CPS] = tx_out;
            if (rx_t / CPS == 9) begin
                last_bits = rx_bits;
                rx_q.push_back(rx_bits[8:1]);
                rx_on = 1'b0;
            end
        end
        tx_prev = tx_out;
    end

    task automatic wait_idle(input int max, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy == 1'b0 && bus.empty == 1'b1) && n < max);
        chk(nm, n < max, 1'b1);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_count"}, rx_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < rx_q.size()) chk(nm, rx_q[i], exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_bytes[$];
        int n;
        int lowcnt;
        bus.data_wr = 1'b0;
        bus.din     = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx",    tx_out,    1'b1);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full",  bus.full,  1'b0);
        chk("rst_ovf",   bus.overflow, 1'b0);

        // Single 0xA5 written on the first edge out of reset.
        busy_cycles = 0;
        rx_q.delete();
        resetn      = 1'b1;
        bus.data_wr = 1'b1;
        bus.din     = 8'hA5;
        @(negedge clk);
        bus.data_wr = 1'b0;
        bus.din     = 8'h3C;
        chk("lat_tx_before", tx_out, 1'b1);
        chk("lat_empty", bus.empty, 1'b0);
        @(negedge clk);
        chk("lat_tx_start", tx_out, 1'b0);
        chk("lat_busy", busy, 1'b1);
        wait_idle(300, "a5_timeout");
        chk("a5_bits", last_bits, 10'b1101001010);
        chk("a5_busy_cycles", busy_cycles, 100);
        exp_bytes = '{8'hA5};
        check_rx("a5_rx", exp_bytes);

        // Three back-to-back bytes.
        repeat (5) @(negedge clk);
        busy_cycles = 0;
        rx_q.delete();
        bus.data_wr = 1'b1;
        bus.din = 8'h55; @(negedge clk);
        bus.din = 8'h0F; @(negedge clk);
        bus.din = 8'hF0; @(negedge clk);
        bus.data_wr = 1'b0;
        bus.din = 8'h99;
        wait_idle(600, "b2b_timeout");
        chk("b2b_busy_cycles", busy_cycles, 300);
        exp_bytes = '{8'h55, 8'h0F, 8'hF0};
        check_rx("b2b_rx", exp_bytes);
        chk("b2b_idle_tx", tx_out, 1'b1);

        // Overflow with a full FIFO, then a write coinciding with a stop-end pop.
        repeat (5) @(negedge clk);
        ovf_cnt = 0;
        rx_q.delete();
        bus.data_wr = 1'b1;
        bus.din = 8'h11;
        @(negedge clk);
        bus.data_wr = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.data_wr = 1'b1;
            bus.din = 8'h21 + 8'(i);
            @(negedge clk);
        end
        bus.data_wr = 1'b0;
        bus.din = 8'hEE;
        chk("ovf_full", bus.full, 1'b1);
        @(negedge clk);
        chk("ovf_pulses", ovf_cnt, 2);
        n = 0;
        while (!(m_active && m_t == FRAME - 1 && mq.size() == DEPTH - 1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("sim_wait", n < 500, 1'b1);
        bus.data_wr = 1'b1;
        bus.din = 8'h27;
        @(negedge clk);
        bus.data_wr = 1'b0;
        bus.din = 8'h00;
        chk("sim_full", bus.full, 1'b0);
        chk("sim_ovf", bus.overflow, 1'b0);
        wait_idle(800, "ovf_timeout");
        chk("ovf_pulses_end", ovf_cnt, 2);
        exp_bytes = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h27};
        check_rx("ovf_rx", exp_bytes);

        // Reset at data bit 4 with two bytes queued.
        repeat (5) @(negedge clk);
        rx_q.delete();
        bus.data_wr = 1'b1;
        bus.din = 8'h3C; @(negedge clk);
        bus.din = 8'h3D; @(negedge clk);
        bus.din = 8'h3E; @(negedge clk);
        bus.data_wr = 1'b0;
        n = 0;
        while (!(m_active && m_t == 5 * CPS + 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait", n < 200, 1'b1);
        chk("rst_queued", bus.empty, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_tx",    tx_out,    1'b1);
        chk("abort_busy",  busy,      1'b0);
        chk("abort_empty", bus.empty, 1'b1);
        lowcnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_out == 1'b0) lowcnt++;
        end
        chk("abort_no_frames", lowcnt, 0);
        chk("abort_rx", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 SHALL have parameter SYSTEM_CLK, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port data_wr  input  1  write strobe; pushes din when full is low.
REQ-007 SHALL have port din  input  8  byte to transmit.
REQ-008 SHALL have port tx_out  output  1  serial line, idle high, registered.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse when data_wr is dropped because full.

Function
REQ-013 SHALL use CYCLES_PER_SYMBOL = SYSTEM_CLK / BAUDRATE (integer division) as symbol length; counter width $clog2(SYSTEM_CLK).
REQ-014 SHALL send 8N1 frames: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-015 SHALL hold every bit, including start and stop, for exactly CYCLES_PER_SYMBOL cycles; frame = 10*CYCLES_PER_SYMBOL cycles.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx_out=1, busy=0; when FIFO non-empty, pop head into shift register, drive tx_out=0, go to START.
REQ-018 START: after CYCLES_PER_SYMBOL cycles, drive bit 0, bit index=0, go to DATA.
REQ-019 DATA: each symbol end, advance to next bit; after bit 7 symbol, drive tx_out=1, go to STOP.
REQ-020 STOP: at symbol end, if FIFO non-empty, pop and drive start bit in same cycle (no idle gap, go to START); else go to IDLE.
REQ-021 Latency: data_wr sampled at edge E with FIFO empty and FSM in IDLE -> tx_out low after edge E+1.
REQ-022 busy SHALL be high from the edge that drives the start bit until the edge returning to IDLE.
REQ-023 FIFO SHALL be first-in first-out with wrap-around read/write pointers and an occupancy count 0..DEPTH.
REQ-024 Write while full SHALL be ignored, FIFO unchanged, overflow pulses high one cycle, even if a pop occurs that cycle.
REQ-025 Simultaneous push (not full) and pop SHALL both take effect; count unchanged.
REQ-026 full and empty SHALL reflect post-edge occupancy, registered or derived from registered count.
REQ-027 din SHALL be captured only on an accepted write; changes to din later SHALL not affect queued data.

Reset
REQ-028 resetn low at any edge SHALL force: tx_out=1, busy=0, overflow=0, empty=1, full=0, FSM=IDLE, counters and pointers=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately (tx_out=1 after that edge) and discard all queued bytes.
REQ-030 First write accepted on the first edge with resetn high.

Verification
REQ-031 SYSTEM_CLK=1_000_000, BAUDRATE=100_000, write 0xA5 -> tx_out after start: 0,1,0,1,0,0,1,0,1,1, each 10 cycles; busy high 100 cycles.
REQ-032 Write 0x55, 0x0F, 0xF0 back-to-back -> three frames, stop bit of each followed directly by next start bit, then idle high.
REQ-033 DEPTH=4, FSM transmitting, write 6 bytes -> full after 4 queued, 5th and 6th each pulse overflow, only first 4 queued + in-flight bytes transmitted in order.
REQ-034 Write on same cycle as STOP-end pop with FIFO at DEPTH-1 -> both accepted, full stays low, no overflow.
REQ-035 Assert resetn low at bit 4 of a frame with 2 bytes queued -> tx_out=1, busy=0, empty=1 next cycle; no further frames.
